// File: rtl/demux1hot_stream.sv
// demux1hot_stream: registered 1-to-N one-hot stream demultiplexer.
// Define DEMUX1HOT_TRUST_SELECT_EN to trust in_sel (lowest bit wins, no error accounting).
module demux1hot_stream #(
   parameter int WIDTH     = 1,
   parameter int NUM_OUT   = 3,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   input  logic [NUM_OUT-1:0]   in_sel,
   output logic [NUM_OUT-1:0]   out_valid,
   input  logic [NUM_OUT-1:0]   out_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic                 err_pulse,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   logic               full;
   logic [WIDTH-1:0]   data_q;
   logic [NUM_OUT-1:0] dest_q;
   logic [NUM_OUT-1:0] route;
   logic               good;
   logic               drain;
   logic               accept;

   // Only the addressed consumer's ready matters.
   assign drain    = full && |(dest_q & out_ready);
   assign in_ready = !full || drain;
   assign accept   = in_valid && in_ready;

`ifdef DEMUX1HOT_TRUST_SELECT_EN
   // Isolate lowest set bit; an all-zero select yields no route.
   assign route     = in_sel & (~in_sel + NUM_OUT'(1));
   assign good      = |in_sel;
   assign err_pulse = 1'b0;
   assign err_cnt   = '0;
`else
   logic [NUM_OUT-1:0]   sel_m1;
   logic                 ep_q;
   logic [ERR_CNT_W-1:0] cnt_q;

   assign sel_m1 = in_sel - NUM_OUT'(1);
   assign route  = in_sel;
   assign good   = (|in_sel) && !(|(in_sel & sel_m1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ep_q  <= 1'b0;
         cnt_q <= '0;
      end else begin
         ep_q <= accept && !good;
         if (accept && !good && (cnt_q != '1))
            cnt_q <= cnt_q + ERR_CNT_W'(1);
      end
   end

   assign err_pulse = ep_q;
   assign err_cnt   = cnt_q;
`endif

   // Reload on a good accept wins over drain, giving 1 beat/cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full   <= 1'b0;
         data_q <= '0;
         dest_q <= '0;
      end else if (accept && good) begin
         full   <= 1'b1;
         data_q <= in_data;
         dest_q <= route;
      end else if (drain) begin
         full   <= 1'b0;
      end
   end

   assign out_valid = full ? dest_q : '0;
   assign out_data  = data_q;

endmodule

// File: doc/demux1hot_stream.md
Name: demux1hot_stream

Overview:
- Registered 1-to-N one-hot demultiplexer: the distribution-side counterpart of the one-hot mux library cells.
- Accepts one valid/ready input stream carrying data plus a one-hot destination select, and delivers each beat to exactly one of NUM_OUT output channels.
- Output side is a single pipeline register with ready pass-through, so full throughput is sustained.
- Malformed selects are dropped and counted; it sits in front of per-destination consumers (queues, FUs) fed from one producer.

Parameters:
- WIDTH, 1, data width in bits
- NUM_OUT, 3, number of output channels (= select width), 2..32
- ERR_CNT_W, 8, width of the saturating bad-select counter

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  block can accept a beat this cycle
- in_data  input  WIDTH  input payload
- in_sel  input  NUM_OUT  one-hot destination select, sampled with in_data
- out_valid  output  NUM_OUT  per-channel valid; at most one bit set
- out_ready  input  NUM_OUT  per-channel ready
- out_data  output  WIDTH  payload, shared by all channels, meaningful only where out_valid set
- err_pulse  output  1  one-cycle pulse: a bad-select beat was dropped last cycle
- err_cnt  output  ERR_CNT_W  saturating count of dropped beats

Behaviour:
- Reset (async assert, sync-safe deassert): holding register empty; out_valid=0, out_data=0, err_pulse=0, err_cnt=0. Reset mid-transfer discards any held beat; no output is produced for it.
- State: full flag, data register, dest register (NUM_OUT bits, one-hot when full).
- Drain: drain = full && |(dest & out_ready).
- Ready: in_ready = !full || drain. Purely combinational from registered state and out_ready; never depends on in_valid or in_sel.
- Accept: accept = in_valid && in_ready.
- Good select: in_sel has exactly one bit set.
  - accept && good: data/dest loaded; full=1 next cycle. Latency is 1 cycle, input accept to out_valid.
  - accept && !good (zero or multiple bits set): beat consumed (in_ready honoured) but not stored; err_pulse=1 next cycle; err_cnt += 1, saturating at all-ones.
- Outputs: out_valid = full ? dest : 0. out_data = data register, held stable while out_valid is set and not drained.
- drain && !accept-good: full=0 next cycle.
- drain && accept-good, same cycle: register reloads with the new beat, full stays 1. Back-to-back beats give 1 beat/cycle even when consecutive destinations differ.
- !drain && full: data/dest held, in_ready=0.
- Consumers' ready for channels other than dest is ignored.
- No reordering; beats leave in acceptance order.
- in_data/in_sel are don't-care when in_valid=0.

Optional Feature:
- Macro DEMUX1HOT_TRUST_SELECT_EN.
- Defined: in_sel trusted. Lowest set bit wins (priority encode to one-hot); zero select is still dropped silently. err_pulse and err_cnt tied to 0, no counter flops.
- Not defined: full one-hot check and error accounting as in Behaviour.

Test Plan:
- Reset, NUM_OUT=3, WIDTH=8: out_valid=000, in_ready=1, err_cnt=0. Assert rst_n low while full: out_valid=000 immediately (async).
- in_data=0xA5, in_sel=010, all out_ready=1: next cycle out_valid=010, out_data=0xA5; drained that cycle; out_valid=000 after.
- Stream 0x01/001, 0x02/100, 0x03/010 on consecutive cycles, out_ready=111: outputs on 3 consecutive cycles with matching one-hot valid; in_ready stays 1.
- Hold 0x11 for dest 100 with out_ready=011 for 4 cycles: in_ready=0, out_data stays 0x11. Raise out_ready[2]: delivered, in_ready=1 same cycle.
- in_sel=011 then 000 with valid: both consumed, no out_valid; err_pulse high 2 cycles; err_cnt=2. 300 bad beats with ERR_CNT_W=8: err_cnt=255.
- With DEMUX1HOT_TRUST_SELECT_EN, in_sel=110, data 0x7E: out_valid=010, out_data=0x7E, err_cnt=0.
